dj8_membus: RTL and testbench

Parametrised memory-bus sequencer for the dj8 CPU. It sits between the CPU core and the chip pins. It decodes each CPU access to either an on-chip ROM or an external bus, and runs the external access as a multi-phase address/data cycle over one shared 8-bit pad bus. Wait states are set by a parameter, the external device can stretch the cycle, and a stuck device is released by a timeout. Completion is returned to the CPU with a one-cycle acknowledge.

---
 rtl/dj8_membus.sv | 182 ++++++++++++++++++
 tb/tb_dj8_membus.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dj8_membus.sv
// rtl/dj8_membus.sv - dj8 memory-bus sequencer: on-chip ROM / multiplexed external bus
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/    CPU access request; command fields are latched at acceptance
//   cpu_wdata
//   cpu_rdata/ack/err   registered read data, one-cycle completion pulse, timeout flag
//   rom_addr/rom_data   on-chip ROM index (from latched address) and its combinational data
//   pad_ad_out/oe/in    shared 8-bit address/data pad bus
//   pad_ale_hi/lo       high/low address latch strobes
//   pad_strobe, pad_we  data-phase strobe and write qualifier
//   ext_wait            cycle-stretch request from the external device

module dj8_membus #(
    parameter int ROM_AW      = 5,
    parameter int ROM_SEL_BIT = 15,
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        pad_ad_out,
    output logic [7:0]        pad_ad_oe,
    input  logic [7:0]        pad_ad_in,
    output logic              pad_ale_hi,
    output logic              pad_ale_lo,
    output logic              pad_strobe,
    output logic              pad_we,
    input  logic              ext_wait
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);
    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROM_RD,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA,
        S_ACK
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [3:0]  wcnt_q, wcnt_d;   // fixed DATA cycles already completed
    logic [7:0]  tcnt_q, tcnt_d;   // ext_wait extension cycles entered so far

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 16'h0000;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
            wcnt_q  <= 4'd0;
            tcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;

        case (state_q)
            S_IDLE: begin
                wcnt_d = 4'd0;
                tcnt_d = 8'd0;
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    err_d   = 1'b0;
                    state_d = cpu_addr[ROM_SEL_BIT] ? S_ROM_RD : S_ADDR_HI;
                end
            end
            S_ROM_RD: begin
                // ROM writes complete silently and leave rdata alone.
                if (!we_q) begin
                    rdata_d = rom_data;
                end
                state_d = S_ACK;
            end
            S_ADDR_HI: state_d = S_ADDR_LO;
            S_ADDR_LO: state_d = S_DATA;
            S_DATA: begin
                if (wcnt_q != WS) begin
                    // Fixed wait cycles: ext_wait is not looked at here.
                    wcnt_d = wcnt_q + 4'd1;
                end else if (ext_wait) begin
                    if (tcnt_q == TO) begin
                        // Device held the bus for the full timeout window.
                        if (!we_q) begin
                            rdata_d = 8'hFF;
                        end
                        err_d   = 1'b1;
                        state_d = S_ACK;
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end else begin
                    if (!we_q) begin
                        rdata_d = pad_ad_in;
                    end
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                // cpu_req is deliberately ignored here.
                wcnt_d  = 4'd0;
                tcnt_d  = 8'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pad drive depends only on state and latched command registers, so
    // nothing from the CPU side reaches the pins combinationally.
    always_comb begin
        pad_ad_out = 8'h00;
        pad_ad_oe  = 8'hFF;
        pad_ale_hi = 1'b0;
        pad_ale_lo = 1'b0;
        pad_strobe = 1'b0;
        pad_we     = 1'b0;
        case (state_q)
            S_ADDR_HI: begin
                pad_ad_out = addr_q[15:8];
                pad_ale_hi = 1'b1;
                pad_we     = we_q;
            end
            S_ADDR_LO: begin
                pad_ad_out = addr_q[7:0];
                pad_ale_lo = 1'b1;
                pad_we     = we_q;
            end
            S_DATA: begin
                pad_strobe = 1'b1;
                pad_we     = we_q;
                pad_ad_out = we_q ? wdata_q : 8'h00;
                pad_ad_oe  = we_q ? 8'hFF : 8'h00;
            end
            default: ;
        endcase
    end

    assign rom_addr  = addr_q[ROM_AW-1:0];
    assign cpu_rdata = rdata_q;
    assign cpu_ack   = (state_q == S_ACK);
    assign cpu_err   = (state_q == S_ACK) && err_q;

endmodule

// File: tb/tb_dj8_membus.sv
// tb/tb_dj8_membus.sv - directed vector bench for dj8_membus

module tb_dj8_membus;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req2 = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  pad_in = 8'h00;
    logic        ext_wait = 1'b0;

    logic [7:0] rom_mem [32];

    logic [7:0] rdata0, pout0, poe0, rom_data0;
    logic       ack0, err0, ahi0, alo0, stb0, pwe0;
    logic [4:0] rom_addr0;
    logic [7:0] rdata2, pout2, poe2, rom_data2;
    logic       ack2, err2, ahi2, alo2, stb2, pwe2;
    logic [4:0] rom_addr2;

    assign rom_data0 = rom_mem[rom_addr0];
    assign rom_data2 = rom_mem[rom_addr2];

    dj8_membus #(.ROM_AW(5), .ROM_SEL_BIT(15), .WAIT_STATES(0), .TIMEOUT(15)) dut0 (
        .clk(clk), .reset(reset), .cpu_req(req0), .cpu_we(we), .cpu_addr(addr),
        .cpu_wdata(wdata), .cpu_rdata(rdata0), .cpu_ack(ack0), .cpu_err(err0),
        .rom_addr(rom_addr0), .rom_data(rom_data0), .pad_ad_out(pout0), .pad_ad_oe(poe0),
        .pad_ad_in(pad_in), .pad_ale_hi(ahi0), .pad_ale_lo(alo0), .pad_strobe(stb0),
        .pad_we(pwe0), .ext_wait(ext_wait));

    dj8_membus #(.ROM_AW(5), .ROM_SEL_BIT(15), .WAIT_STATES(2), .TIMEOUT(15)) dut2 (
        .clk(clk), .reset(reset), .cpu_req(req2), .cpu_we(we), .cpu_addr(addr),
        .cpu_wdata(wdata), .cpu_rdata(rdata2), .cpu_ack(ack2), .cpu_err(err2),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .pad_ad_out(pout2), .pad_ad_oe(poe2),
        .pad_ad_in(pad_in), .pad_ale_hi(ahi2), .pad_ale_lo(alo2), .pad_strobe(stb2),
        .pad_we(pwe2), .ext_wait(ext_wait));

    always #5 clk = ~clk;

    logic [19:0] p0, p2;
    assign p0 = {pout0, poe0, ahi0, alo0, stb0, pwe0};
    assign p2 = {pout2, poe2, ahi2, alo2, stb2, pwe2};

    localparam logic [19:0] IDLE_P = {8'h00, 8'hFF, 4'b0000};

    function automatic logic [19:0] pk(input logic [7:0] o, input logic [7:0] oe,
                                       input logic hi, input logic lo,
                                       input logic stb, input logic w);
        return {o, oe, hi, lo, stb, w};
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  pin;
        int          ext;     // cycles ext_wait is held high from the first DATA cycle
        int          lat;     // ack cycle relative to acceptance
        logic [7:0]  rdata;
        logic        err;
    } vec_t;

    vec_t vecs[12];

    // One access on dut0 (WAIT_STATES = 0); command inputs are scrambled right
    // after acceptance to show they are latched.
    task automatic run0(input vec_t v, input string tag);
        int  k;
        bit  seen;
        bit  pads_idle;
        @(negedge clk);
        we = v.we; addr = v.addr; wdata = v.wdata; pad_in = v.pin; ext_wait = 1'b0;
        req0 = 1'b1;
        k = 0; seen = 0; pads_idle = 1;
        while (!seen && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                addr = ~v.addr; wdata = ~v.wdata; we = ~v.we;
            end
            ext_wait = (k >= 3 && k < 3 + v.ext);
            if (p0 !== IDLE_P) pads_idle = 0;
            if (ack0) seen = 1;
        end
        check({tag, " latency"}, k, v.lat);
        check({tag, " rdata"}, rdata0, v.rdata);
        check({tag, " err"}, err0, v.err);
        if (v.addr[15]) check({tag, " rom pads idle"}, pads_idle, 1);
        req0 = 1'b0; ext_wait = 1'b0;
        @(posedge clk); #1;
        check({tag, " ack one cycle"}, ack0, 1'b0);
    endtask

    initial begin
        logic [19:0] exp_p [7];
        logic [9:0]  mask;

        for (int i = 0; i < 32; i++) rom_mem[i] = 8'(i);
        rom_mem[0]  = 8'hF8;
        rom_mem[3]  = 8'h9C;
        rom_mem[31] = 8'hE1;

        //             we    addr      wdata  pin    ext  lat rdata  err
        vecs[0]  = '{1'b0, 16'h8003, 8'h00, 8'h00,   0,  2, 8'h9C, 1'b0};
        vecs[1]  = '{1'b0, 16'h1234, 8'h00, 8'h5A,   0,  4, 8'h5A, 1'b0};
        vecs[2]  = '{1'b0, 16'h4321, 8'h00, 8'h3C,   4,  8, 8'h3C, 1'b0};
        vecs[3]  = '{1'b0, 16'h0777, 8'h00, 8'h5A, 100, 19, 8'hFF, 1'b1};
        vecs[4]  = '{1'b0, 16'h0100, 8'h00, 8'h77,   0,  4, 8'h77, 1'b0};
        vecs[5]  = '{1'b1, 16'h8005, 8'h11, 8'h00,   0,  2, 8'h77, 1'b0};
        vecs[6]  = '{1'b1, 16'h00F0, 8'hA5, 8'h66,   0,  4, 8'h77, 1'b0};
        vecs[7]  = '{1'b0, 16'h2A2A, 8'h00, 8'hC3,  15, 19, 8'hC3, 1'b0};
        vecs[8]  = '{1'b0, 16'h7FFF, 8'h00, 8'h81,  16, 19, 8'hFF, 1'b1};
        vecs[9]  = '{1'b0, 16'h801F, 8'h00, 8'h00,   0,  2, 8'hE1, 1'b0};
        vecs[10] = '{1'b1, 16'h0010, 8'h42, 8'h00,   2,  6, 8'hE1, 1'b0};
        vecs[11] = '{1'b1, 16'h0300, 8'h99, 8'h00, 100, 19, 8'hE1, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset rdata0", rdata0, 8'h00);
        check("reset ack0", ack0, 1'b0);
        check("reset err0", err0, 1'b0);
        check("reset pads0", p0, IDLE_P);
        check("reset rdata2", rdata2, 8'h00);
        check("reset pads2", p2, IDLE_P);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run0(vecs[i], $sformatf("v%0d", i));

        // Pad phases of an external read, WAIT_STATES = 0
        @(negedge clk);
        we = 1'b0; addr = 16'h1234; pad_in = 8'h5A; req0 = 1'b1;
        exp_p[1] = pk(8'h12, 8'hFF, 1, 0, 0, 0);
        exp_p[2] = pk(8'h34, 8'hFF, 0, 1, 0, 0);
        exp_p[3] = pk(8'h00, 8'h00, 0, 0, 1, 0);
        exp_p[4] = IDLE_P;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("rd pads k%0d", k), p0, exp_p[k]);
            check($sformatf("rd ack k%0d", k), ack0, (k == 4));
        end
        check("rd rdata", rdata0, 8'h5A);
        req0 = 1'b0;
        @(posedge clk); #1;

        // External write on the WAIT_STATES = 2 instance
        @(negedge clk);
        we = 1'b1; addr = 16'h00F0; wdata = 8'hA5; req2 = 1'b1;
        exp_p[1] = pk(8'h00, 8'hFF, 1, 0, 0, 1);
        exp_p[2] = pk(8'hF0, 8'hFF, 0, 1, 0, 1);
        exp_p[3] = pk(8'hA5, 8'hFF, 0, 0, 1, 1);
        exp_p[4] = exp_p[3];
        exp_p[5] = exp_p[3];
        exp_p[6] = IDLE_P;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                addr = 16'hFFFF; wdata = 8'h00; we = 1'b0;
            end
            check($sformatf("wr2 pads k%0d", k), p2, exp_p[k]);
            check($sformatf("wr2 ack k%0d", k), ack2, (k == 6));
        end
        check("wr2 rdata unchanged", rdata2, 8'h00);
        check("wr2 err", err2, 1'b0);
        req2 = 1'b0;
        @(posedge clk); #1;

        // Back-to-back ROM reads with req held: acks every 3 cycles
        @(negedge clk);
        we = 1'b0; addr = 16'h8003; req0 = 1'b1;
        mask = '0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            mask[k-1] = ack0;
            if (k == 9) req0 = 1'b0;
        end
        check("b2b rom acks", mask, 10'b0010010010);
        @(posedge clk); #1;

        // Back-to-back external reads: acks every WAIT_STATES+5 cycles
        @(negedge clk);
        we = 1'b0; addr = 16'h0100; pad_in = 8'h77; req0 = 1'b1;
        mask = '0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            mask[k-1] = ack0;
            if (k == 10) req0 = 1'b0;
        end
        check("b2b ext acks", mask, 10'b0100001000);
        @(posedge clk); #1;

        // Reset during ADDR_LO
        @(negedge clk);
        we = 1'b0; addr = 16'h1234; pad_in = 8'h5A; req0 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst pre ale_lo", p0, pk(8'h34, 8'hFF, 0, 1, 0, 0));
        reset = 1'b1; req0 = 1'b0;
        @(posedge clk); #1;
        check("rst pads idle", p0, IDLE_P);
        check("rst no ack", ack0, 1'b0);
        check("rst rdata", rdata0, 8'h00);
        reset = 1'b0;
        mask = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            mask[k] = ack0;
        end
        check("rst no late ack", mask, 10'b0);
        run0('{1'b0, 16'h8000, 8'h00, 8'h00, 0, 2, 8'hF8, 1'b0}, "post-rst rom");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
